// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo requester slice.
//   echo_state_e : burst sequencer states (IDLE, RUN, DRAIN, DONE)
//   PAYLOAD_W    : width of echo request / indication payloads
//   LAT_W        : width of the latency timestamp and status_max_latency
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } echo_state_e;

  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned LAT_W     = 16;

endpackage

// File: rtl/echo_ts_fifo.sv
// echo_ts_fifo: DEPTH x W timestamp FIFO used for request-to-echo latency.
// Only instantiated when ECHO_REQ_LATENCY_EN is defined.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous pointer clear (start of a new burst)
//   push_i/data_i : write a timestamp
//   pop_i/data_o  : head of queue (combinational), advanced by pop_i
// The caller's outstanding-request credit bounds occupancy, so no
// full/empty flags are kept.
module echo_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/echo_requester.sv
// echo_requester: initiator side of the echo request/indication protocol.
// Issues a burst of echoReq calls (seed, seed+1, ...), accepts echo
// indications in order, compares each against the expected sequence and
// reports received / error counts.
// Ports:
//   CLK, nRST                        : clock, asynchronous active-low reset
//   start__ENA/_count/_seed/__RDY    : burst start handshake
//   echoReq__ENA/_v/__RDY            : request issue toward the responder
//   echo__ENA/_v/__RDY               : returning indications
//   status_busy/_done                : RUN or DRAIN / DONE
//   status_received/_errors          : saturating burst counters
//   status_max_latency               : worst request-to-echo latency
// Optional feature macro: ECHO_REQ_LATENCY_EN (latency measurement);
// without it status_max_latency is tied to zero.
module echo_requester
  import echo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start__ENA,
  input  logic [CNT_W-1:0]     start_count,
  input  logic [PAYLOAD_W-1:0] start_seed,
  output logic                 start__RDY,
  output logic                 echoReq__ENA,
  output logic [PAYLOAD_W-1:0] echoReq_v,
  input  logic                 echoReq__RDY,
  input  logic                 echo__ENA,
  input  logic [PAYLOAD_W-1:0] echo_v,
  output logic                 echo__RDY,
  output logic                 status_busy,
  output logic                 status_done,
  output logic [CNT_W-1:0]     status_received,
  output logic [CNT_W-1:0]     status_errors,
  output logic [LAT_W-1:0]     status_max_latency
);

  localparam int unsigned OUT_W = $clog2(DEPTH + 1);

  echo_state_e          state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     received_q, received_d;
  logic [CNT_W-1:0]     errors_q, errors_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [PAYLOAD_W-1:0] req_v_q, req_v_d;
  logic [PAYLOAD_W-1:0] exp_q, exp_d;

  logic start_take;
  logic issue;
  logic accept;

  always_comb begin
    start__RDY = (state_q == IDLE) || (state_q == DONE);
    echo__RDY  = ((state_q == RUN) || (state_q == DRAIN)) && (outstanding_q != '0);
    issue      = (state_q == RUN) && (issued_q < count_q)
                 && (outstanding_q < OUT_W'(DEPTH)) && echoReq__RDY;
    accept     = echo__ENA && echo__RDY;
    start_take = start__RDY && start__ENA;
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    issued_d      = issued_q;
    received_d    = received_q;
    errors_d      = errors_q;
    outstanding_d = outstanding_q;
    req_v_d       = req_v_q;
    exp_d         = exp_q;

    if (issue) begin
      issued_d = issued_q + CNT_W'(1);
      req_v_d  = req_v_q + PAYLOAD_W'(1);
    end

    if (accept) begin
      if ((echo_v != exp_q) && (errors_q != '1)) errors_d = errors_q + CNT_W'(1);
      if (received_q != '1) received_d = received_q + CNT_W'(1);
      exp_d = exp_q + PAYLOAD_W'(1);
    end

    unique case ({issue, accept})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    unique case (state_q)
      IDLE, DONE: begin
        if (start__ENA) begin
          count_d       = start_count;
          issued_d      = '0;
          received_d    = '0;
          errors_d      = '0;
          outstanding_d = '0;
          req_v_d       = start_seed;
          exp_d         = start_seed;
          state_d       = (start_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (issued_q == count_q - CNT_W'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept && (outstanding_q == OUT_W'(1))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      errors_q      <= '0;
      outstanding_q <= '0;
      req_v_q       <= '0;
      exp_q         <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      errors_q      <= errors_d;
      outstanding_q <= outstanding_d;
      req_v_q       <= req_v_d;
      exp_q         <= exp_d;
    end
  end

  assign echoReq__ENA    = issue;
  assign echoReq_v       = req_v_q;
  assign status_busy     = (state_q == RUN) || (state_q == DRAIN);
  assign status_done     = (state_q == DONE);
  assign status_received = received_q;
  assign status_errors   = errors_q;

`ifdef ECHO_REQ_LATENCY_EN
  logic [LAT_W-1:0] now_q;
  logic [LAT_W-1:0] ts;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] max_lat_q, max_lat_d;

  echo_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (LAT_W)
  ) u_ts_fifo (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .clr_i  (start_take),
    .push_i (issue),
    .data_i (now_q),
    .pop_i  (accept),
    .data_o (ts)
  );

  assign lat = now_q - ts;

  always_comb begin
    max_lat_d = max_lat_q;
    if (start_take) begin
      max_lat_d = '0;
    end else if (accept && (lat > max_lat_q)) begin
      max_lat_d = lat;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      now_q     <= '0;
      max_lat_q <= '0;
    end else begin
      now_q     <= now_q + LAT_W'(1);
      max_lat_q <= max_lat_d;
    end
  end

  assign status_max_latency = max_lat_q;
`else
  assign status_max_latency = '0;
`endif

endmodule

// File: tb/tb_echo_requester.sv
module tb_echo_requester;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
`ifdef ECHO_REQ_LATENCY_EN
  localparam logic [31:0] LAT_EXP = 32'd3;
`else
  localparam logic [31:0] LAT_EXP = 32'd0;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start_ena;
  logic [CNT_W-1:0] start_count;
  logic [31:0]      start_seed;
  logic             start_rdy;
  logic             req_ena;
  logic [31:0]      req_v;
  logic             req_rdy;
  logic             echo_ena;
  logic [31:0]      echo_v;
  logic             echo_rdy;
  logic             st_busy;
  logic             st_done;
  logic [CNT_W-1:0] st_received;
  logic [CNT_W-1:0] st_errors;
  logic [15:0]      st_max_lat;

  echo_requester #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .start__ENA         (start_ena),
    .start_count        (start_count),
    .start_seed         (start_seed),
    .start__RDY         (start_rdy),
    .echoReq__ENA       (req_ena),
    .echoReq_v          (req_v),
    .echoReq__RDY       (req_rdy),
    .echo__ENA          (echo_ena),
    .echo_v             (echo_v),
    .echo__RDY          (echo_rdy),
    .status_busy        (st_busy),
    .status_done        (st_done),
    .status_received    (st_received),
    .status_errors      (st_errors),
    .status_max_latency (st_max_lat)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] pay [16];
  int n_pay;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_burst(input logic [CNT_W-1:0] cnt, input logic [31:0] seed,
                           input int dly, input int bad_idx, input int stall,
                           output int stall_issues, output int max_out);
    int q_due[$];
    logic [31:0] q_val[$];
    int issued, accepted, dummy;
    bit done_seen;
    issued = 0; accepted = 0; stall_issues = 0; max_out = 0; done_seen = 0; n_pay = 0;
    start_ena = 1'b1; start_count = cnt; start_seed = seed; echo_ena = 1'b0;
    #4;
    check_eq("start_rdy_before_burst", 32'(start_rdy), 32'd1);
    next_cycle();
    start_ena = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      echo_ena = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc && cyc >= stall) begin
        echo_ena = 1'b1;
        echo_v   = (accepted == bad_idx) ? 32'h0000_DEAD : q_val[0];
      end
      #4;
      if (st_done) begin
        done_seen = 1'b1;
      end else begin
        if (req_ena) begin
          check_eq("payload_order", req_v, seed + 32'(issued));
          if (n_pay < 16) pay[n_pay] = req_v;
          n_pay++;
          q_due.push_back(cyc + dly);
          q_val.push_back(req_v);
          issued++;
          if (cyc < stall) stall_issues++;
        end
        if (echo_ena && echo_rdy) begin
          dummy = q_due.pop_front();
          void'(q_val.pop_front());
          accepted++;
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
      end
      next_cycle();
    end
    echo_ena = 1'b0;
    if (!done_seen) check_eq("done_timeout", 32'(st_done), 32'd1);
    check_eq("issued_total", 32'(issued), 32'(cnt));
    check_eq("accepted_total", 32'(accepted), 32'(cnt));
  endtask

  task automatic check_final(input logic [31:0] rx, input logic [31:0] errs);
    #4;
    check_eq("final_received", 32'(st_received), rx);
    check_eq("final_errors", 32'(st_errors), errs);
    check_eq("final_done", 32'(st_done), 32'd1);
    check_eq("final_busy", 32'(st_busy), 32'd0);
    check_eq("final_start_rdy", 32'(start_rdy), 32'd1);
    next_cycle();
  endtask

  int si, mo;
  logic [31:0] wrap_exp [4];

  initial begin
    nRST = 1'b0; start_ena = 1'b0; start_count = '0; start_seed = '0;
    req_rdy = 1'b1; echo_ena = 1'b0; echo_v = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_start_rdy", 32'(start_rdy), 32'd1);
    check_eq("rst_req_ena", 32'(req_ena), 32'd0);
    check_eq("rst_req_v", req_v, 32'd0);
    check_eq("rst_echo_rdy", 32'(echo_rdy), 32'd0);
    check_eq("rst_received", 32'(st_received), 32'd0);
    check_eq("rst_max_lat", 32'(st_max_lat), 32'd0);
    nRST = 1'b1;
    next_cycle();

    echo_ena = 1'b1; echo_v = 32'h0;
    #4;
    check_eq("idle_echo_rdy", 32'(echo_rdy), 32'd0);
    next_cycle();
    echo_ena = 1'b0;
    #4;
    check_eq("idle_spurious_received", 32'(st_received), 32'd0);
    next_cycle();

    start_ena = 1'b1; start_count = '0; start_seed = 32'h5;
    #4;
    check_eq("cnt0_req_ena_start", 32'(req_ena), 32'd0);
    next_cycle();
    start_ena = 1'b0;
    #4;
    check_eq("cnt0_done", 32'(st_done), 32'd1);
    check_eq("cnt0_req_ena", 32'(req_ena), 32'd0);
    check_eq("cnt0_received", 32'(st_received), 32'd0);
    next_cycle();

    run_burst(16'd8, 32'h10, 3, -1, 0, si, mo);
    check_eq("loop_first_payload", pay[0], 32'h10);
    check_eq("loop_last_payload", pay[7], 32'h17);
    check_eq("loop_max_latency", 32'(st_max_lat), LAT_EXP);
    check_final(32'd8, 32'd0);

    run_burst(16'd10, 32'h40, 1, -1, 12, si, mo);
    check_eq("stall_issues", 32'(si), 32'd4);
    check_eq("stall_max_outstanding", 32'(mo), 32'(DEPTH));
    check_final(32'd10, 32'd0);

    run_burst(16'd6, 32'h100, 2, 2, 0, si, mo);
    check_final(32'd6, 32'd1);

    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
    run_burst(16'd4, 32'hFFFF_FFFE, 2, -1, 0, si, mo);
    for (int unsigned i = 0; i < 4; i++) check_eq($sformatf("wrap_payload%0d", i), pay[i], wrap_exp[i]);
    check_final(32'd4, 32'd0);

    start_ena = 1'b1; start_count = 16'd8; start_seed = 32'h200;
    next_cycle();
    start_ena = 1'b0;
    next_cycle();
    next_cycle();
    req_rdy = 1'b0;
    #1;
    check_eq("mid_echo_rdy", 32'(echo_rdy), 32'd1);
    check_eq("mid_busy", 32'(st_busy), 32'd1);
    nRST = 1'b0;
    #1;
    check_eq("mid_rst_start_rdy", 32'(start_rdy), 32'd1);
    check_eq("mid_rst_req_ena", 32'(req_ena), 32'd0);
    check_eq("mid_rst_req_v", req_v, 32'd0);
    check_eq("mid_rst_echo_rdy", 32'(echo_rdy), 32'd0);
    check_eq("mid_rst_busy", 32'(st_busy), 32'd0);
    check_eq("mid_rst_done", 32'(st_done), 32'd0);
    check_eq("mid_rst_max_lat", 32'(st_max_lat), 32'd0);
    next_cycle();
    nRST = 1'b1; req_rdy = 1'b1;
    echo_ena = 1'b1; echo_v = 32'h200;
    #3;
    check_eq("late_echo_rdy", 32'(echo_rdy), 32'd0);
    next_cycle();
    echo_ena = 1'b0;
    #3;
    check_eq("late_echo_received", 32'(st_received), 32'd0);
    check_eq("late_echo_start_rdy", 32'(start_rdy), 32'd1);
    next_cycle();
    run_burst(16'd3, 32'h300, 1, -1, 0, si, mo);
    check_final(32'd3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/echo_requester.md
# echo_requester

Initiator side of the echo request/indication protocol. Issues a programmed burst of `echoReq` calls toward the echo responder, accepts the returning `echo` indications, checks each returned value against the expected sequence, and reports received and error counts. It sits in front of the responder in loopback test builds and as the host-side traffic source in simulation.

## Interface
- DEPTH, 4, maximum outstanding requests (credits), 1..16
- CNT_W, 16, width of burst length and status counters
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- start__ENA  in  1  begin burst; honoured only while start__RDY
- start$count  in  CNT_W  number of requests in the burst
- start$seed  in  32  value of the first request
- start__RDY  out  1  high in IDLE or DONE
- echoReq__ENA  out  1  request issue strobe
- echoReq$v  out  32  request payload
- echoReq__RDY  in  1  responder can accept a request
- echo__ENA  in  1  indication strobe from responder
- echo$v  in  32  echoed payload
- echo__RDY  out  1  requester can accept an indication
- status$busy  out  1  state is RUN or DRAIN
- status$done  out  1  state is DONE
- status$received  out  CNT_W  indications accepted in this burst
- status$errors  out  CNT_W  indications whose value mismatched
- status$max_latency  out  16  worst request-to-echo latency in cycles (0 when feature compiled out)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start__ENA: latch count and seed, clear issued, received, errors, outstanding, max_latency; go RUN (or DONE directly if count==0).
- RUN: echoReq__ENA = (issued < count) & (outstanding < DEPTH) & echoReq__RDY. echoReq$v = seed + issued (mod 2^32). On issue: issued++, outstanding++.
- RUN -> DRAIN when the last request issues (issued reaches count).
- echo__RDY = (state RUN or DRAIN) & (outstanding != 0). Indication accepted only when echo__ENA & echo__RDY; echo__ENA while echo__RDY low is ignored and changes no state.
- On accept: expected = seed + received (mod 2^32); if echo$v != expected then errors++; received++, outstanding--.
- Issue and accept in the same cycle: outstanding unchanged; both counters update.
- DRAIN -> DONE when outstanding reaches 0 after the final accept.
- status$errors and status$received saturate at 2^CNT_W-1; they hold their values in DONE until the next start.
- Reset mid-burst: all state discarded immediately; any in-flight echoes arriving after reset see echo__RDY low and are dropped.

## Timing
- Reset values: state IDLE; start__RDY 1; echoReq__ENA 0; echoReq$v 0; echo__RDY 0; all status outputs 0.
- echoReq__ENA and echo__RDY are combinational from registered state and echoReq__RDY only; echoReq$v is purely registered.
- start accepted in cycle N: first echoReq__ENA possible in cycle N+1.
- One request and one indication per cycle maximum; full DEPTH throughput when the responder returns one echo per cycle.
- Status counters update the cycle after the accepting edge; status$done rises the cycle after the last accept.

## Configuration
- ECHO_REQ_LATENCY_EN defined: free-running 16-bit cycle counter; each issue pushes its timestamp into a DEPTH-entry FIFO, each accept pops it; latency = now - timestamp (mod 2^16); status$max_latency keeps the maximum.
- Not defined: no timestamp storage; status$max_latency tied to 0.

## Structure
- Shared package echo_pkg: state enum (IDLE, RUN, DRAIN, DONE), payload width constant 32, latency width constant 16.
- Sub-module echo_ts_fifo: DEPTH x 16 timestamp FIFO, instantiated only under ECHO_REQ_LATENCY_EN; never full or empty at use because outstanding bounds it.

## Test plan
- Loopback, count=8, seed=0x10, responder echoes after 3 cycles -> requests 0x10..0x17 in order, received=8, errors=0, done set, max_latency=3 with latency enabled.
- Responder stalls echoes, DEPTH=4, count=10 -> exactly 4 issues then echoReq__ENA held low until an echo is accepted; outstanding never exceeds 4.
- Responder corrupts the 3rd echo (returns 0xDEAD) with seed=0x100 -> errors=1, received=count, remaining values all match.
- seed=0xFFFFFFFE, count=4 -> payloads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; errors=0.
- count=0 -> no echoReq__ENA, done the cycle after start; spurious echo__ENA while IDLE -> ignored, received stays 0.
- nRST asserted mid-burst with 2 outstanding -> all outputs at reset values immediately; late echoes dropped; new start runs cleanly.
